// File: rtl/int_addsub_pipe.sv
// Pipelined integer add/subtract with a segmented carry chain, overflow detection and optional saturation.
// Latency: STAGES cycles from acceptance to out_valid; one beat per cycle when out_ready stays high.
// Backpressure: the whole pipeline freezes while out_valid & ~out_ready, and in_ready drops in the same cycle.
module int_addsub_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  carry_in,
    input  logic                  op_sub,
    input  logic                  signed_mode,
    input  logic                  sat_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  carry_out,
    output logic                  overflow
);

    localparam int SEG = DATA_WIDTH / STAGES;

    localparam logic [DATA_WIDTH-1:0] SAT_SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] SAT_UMAX = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] SAT_UMIN = {DATA_WIDTH{1'b0}};

    // bx holds the operand already inverted for subtract; cin is the running chain carry.
    typedef struct packed {
        logic                  vld;
        logic                  op_sub;
        logic                  sgn;
        logic                  sat;
        logic                  cin;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] bx;
        logic [DATA_WIDTH-1:0] psum;
        logic                  cout;
        logic                  ovf;
    } stage_t;

    stage_t st_q [STAGES];
    stage_t st_d [STAGES];
    stage_t src  [STAGES];
    logic   adv;

    assign adv       = ~st_q[STAGES-1].vld | out_ready;
    assign in_ready  = adv;
    assign out_valid = st_q[STAGES-1].vld;
    assign sum       = st_q[STAGES-1].psum;
    assign carry_out = st_q[STAGES-1].cout;
    assign overflow  = st_q[STAGES-1].ovf;

    always_comb begin
        src[0]        = '0;
        src[0].vld    = in_valid;
        src[0].op_sub = op_sub;
        src[0].sgn    = signed_mode;
        src[0].sat    = sat_en;
        src[0].cin    = op_sub ? ~carry_in : carry_in;
        src[0].a      = data_a;
        src[0].bx     = op_sub ? ~data_b : data_b;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = st_q[k-1];
        end
    end

    always_comb begin
        stage_t         cur;
        logic [SEG:0]   seg_r;
        for (int k = 0; k < STAGES; k++) begin
            cur   = src[k];
            seg_r = {1'b0, cur.a[k*SEG +: SEG]} + {1'b0, cur.bx[k*SEG +: SEG]}
                  + {{SEG{1'b0}}, cur.cin};
            cur.psum[k*SEG +: SEG] = seg_r[SEG-1:0];
            cur.cin                = seg_r[SEG];
            if (k == STAGES - 1) begin
                // Subtract reports an active-high borrow, the inverse of the raw carry.
                cur.cout = cur.op_sub ? ~cur.cin : cur.cin;
                cur.ovf  = cur.sgn ? ((cur.a[DATA_WIDTH-1] == cur.bx[DATA_WIDTH-1]) &&
                                      (cur.psum[DATA_WIDTH-1] != cur.a[DATA_WIDTH-1]))
                                   : cur.cout;
                if (cur.sat && cur.ovf) begin
                    if (cur.sgn) begin
                        cur.psum = cur.a[DATA_WIDTH-1] ? SAT_SMIN : SAT_SMAX;
                    end else begin
                        cur.psum = cur.op_sub ? SAT_UMIN : SAT_UMAX;
                    end
                end
            end
            st_d[k] = adv ? cur : st_q[k];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (rst) begin
                st_q[k] <= '0;
            end else begin
                st_q[k] <= st_d[k];
            end
        end
    end

endmodule

// File: tb/tb_int_addsub_pipe.sv
// Directed and random stimulus for int_addsub_pipe (8-bit, 2 stages) checked against a queue-based scoreboard.
module tb_int_addsub_pipe;

    localparam int W  = 8;
    localparam int ST = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic         carry_in;
    logic         op_sub;
    logic         signed_mode;
    logic         sat_en;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int_addsub_pipe #(.DATA_WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_a(data_a), .data_b(data_b), .carry_in(carry_in),
        .op_sub(op_sub), .signed_mode(signed_mode), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   last_stall = -1;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;
    int   n_in = 0;
    int   n_out = 0;
    logic         hold_vld = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_cout;
    logic         hold_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference computed in plain integer arithmetic, independent of any bit-level carry chain.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                   input logic sub, input logic sg, input logic sa_en);
        exp_t e;
        int   ua, ub, r, sa, sb_v, rs;
        logic sovf;
        ua   = a;
        ub   = b;
        sa   = $signed(a);
        sb_v = $signed(b);
        r    = sub ? (ua - ub - ci) : (ua + ub + ci);
        rs   = sub ? (sa - sb_v - ci) : (sa + sb_v + ci);
        e.cout = sub ? (r < 0) : (r > 255);
        sovf   = (rs > 127) || (rs < -128);
        e.ovf  = sg ? sovf : e.cout;
        e.sum  = r[W-1:0];
        if (sa_en && e.ovf) begin
            if (sg) e.sum = (sa < 0) ? 8'h80 : 8'h7F;
            else    e.sum = sub ? 8'h00 : 8'hFF;
        end
        e.acc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                check("hold_valid", out_valid, 1);
                check("hold_sum", sum, hold_sum);
                check("hold_cout", carry_out, hold_cout);
                check("hold_ovf", overflow, hold_ovf);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    check("sum", sum, e.sum);
                    check("carry_out", carry_out, e.cout);
                    check("overflow", overflow, e.ovf);
                    if (last_stall < e.acc) check("latency", cyc - e.acc, ST);
                end
            end
            hold_vld  = out_valid && !out_ready;
            hold_sum  = sum;
            hold_cout = carry_out;
            hold_ovf  = overflow;
            if (out_valid && !out_ready) last_stall = cyc;
            if (in_valid && in_ready) begin
                e     = model(data_a, data_b, carry_in, op_sub, signed_mode, sat_en);
                e.acc = cyc;
                sb.push_back(e);
                n_in++;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sub, input logic sg, input logic sa_en, output int waits);
        data_a      = a;
        data_b      = b;
        carry_in    = ci;
        op_sub      = sub;
        signed_mode = sg;
        sat_en      = sa_en;
        in_valid    = 1'b1;
        waits       = 0;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        data_a = '0; data_b = '0; carry_in = 1'b0;
        op_sub = 1'b0; signed_mode = 1'b0; sat_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry_out", carry_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed corner cases: unsigned wrap, unsigned saturate, signed subtract, cross-segment carry.
        send(8'hF0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, w);
        send(8'hF0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, w);
        send(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, w);
        send(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, w);
        send(8'h0F, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, w);
        send(8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, w);
        send(8'h7F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, w);
        drain();

        for (int i = 0; i < 24; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        drain();

        // Six-beat stream with a three-cycle downstream stall after the third beat.
        send(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, w);
        send(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, w);
        send(8'h05, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, w);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_a = 8'($urandom); data_b = 8'($urandom); op_sub = 1'($urandom);
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'h07, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, w);
        send(8'h09, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, w);
        send(8'h0B, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0, w);
        drain();

        // Reset with two beats in flight: both are discarded, and intake resumes at once.
        send(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, w);
        send(8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, w);
        rst = 1'b1;
        n_in = n_in - sb.size();
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send(8'h55, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, w);
        check("midrst_accept_waits", w, 0);
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("beat_count", n_out, n_in);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/int_addsub_pipe.md
INT_ADDSUB_PIPE -- requirements
Module: int_addsub_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width; SHALL be at least 2.
REQ-002 Parameter STAGES, default 2: pipeline depth and carry-chain segment count; SHALL be 1..8 with DATA_WIDTH divisible by STAGES.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 data_a  input  DATA_WIDTH  first operand.
REQ-008 data_b  input  DATA_WIDTH  second operand.
REQ-009 carry_in  input  1  carry-in for add, borrow-in for subtract.
REQ-010 op_sub  input  1  0 = add, 1 = subtract.
REQ-011 signed_mode  input  1  1 = two's-complement overflow and saturation rules.
REQ-012 sat_en  input  1  1 = clamp the result on overflow.
REQ-013 out_valid  output  1  result beat present.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 sum  output  DATA_WIDTH  result.
REQ-016 carry_out  output  1  carry-out for add, borrow-out for subtract.
REQ-017 overflow  output  1  range violation flag.

Function
REQ-018 Carry chain: SHALL be split into STAGES segments of DATA_WIDTH/STAGES bits.
- Segment k SHALL be computed in pipeline stage k.
- Its carry SHALL be registered and fed to segment k+1.
- Operand upper bits and control bits (op_sub, signed_mode, sat_en) SHALL travel alongside the chain.
REQ-019 Add: raw = data_a + data_b + carry_in, taken over DATA_WIDTH+1 bits; carry_out = raw[DATA_WIDTH].
REQ-020 Subtract: raw = data_a + ~data_b + ~carry_in; carry_out = ~raw[DATA_WIDTH] (borrow, active-high).
REQ-021 Unsigned overflow (signed_mode = 0): overflow SHALL equal carry_out.
REQ-022 Signed overflow (signed_mode = 1): overflow SHALL be set when the operand signs agree (add) or differ (subtract) and the result sign differs from data_a's sign.
REQ-023 Saturation, applied only when sat_en = 1 and overflow = 1:
- Signed: sum SHALL be the most positive value if data_a is non-negative, else the most negative value.
- Unsigned add: sum SHALL be all ones.
- Unsigned subtract: sum SHALL be zero.
- carry_out and overflow SHALL still report the raw condition.
REQ-024 Otherwise sum SHALL equal raw[DATA_WIDTH-1:0].
REQ-025 Stage enable: adv = ~out_valid | out_ready.
- All pipeline registers, including per-stage valid bits, SHALL load only when adv = 1.
- in_ready SHALL equal adv.
REQ-026 A beat SHALL be accepted when in_valid & in_ready; latency from acceptance to out_valid SHALL be exactly STAGES cycles when out_ready stays high.
REQ-027 Throughput SHALL be one beat per cycle with out_ready held high; bubbles SHALL propagate as invalid stages.
REQ-028 While out_valid & ~out_ready: sum, carry_out and overflow SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-029 Beats SHALL emerge in acceptance order.
REQ-030 Outputs and pipeline contents SHALL NOT change when adv = 0, whatever in_valid, data_a, data_b or the mode inputs do.
REQ-031 STAGES = 1: the block SHALL behave as a single registered stage with the same handshake.

Reset
REQ-032 While rst = 1 at a clock edge, every stage valid bit and out_valid SHALL clear to 0, and sum, carry_out and overflow SHALL clear to 0.
REQ-033 Reset SHALL override adv and any handshake in the same cycle; in-flight beats SHALL be discarded.
REQ-034 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-035 DATA_WIDTH = 8, STAGES = 2, unsigned add, sat_en = 0: 0xF0 + 0x20, carry_in = 0 -> sum 0x10, carry_out 1, overflow 1, out_valid exactly 2 cycles after acceptance.
REQ-036 Same operands with sat_en = 1 -> sum 0xFF, carry_out 1, overflow 1.
REQ-037 Signed subtract 0x80 - 0x01, carry_in = 0:
- sat_en = 0 -> sum 0x7F, overflow 1, carry_out 0.
- sat_en = 1 -> sum 0x80.
REQ-038 Cross-segment carry: unsigned add 0x0F + 0x01, carry_in = 1 -> sum 0x11, carry_out 0, overflow 0.
REQ-039 Backpressure: stream 6 back-to-back beats, hold out_ready = 0 for 3 cycles mid-stream -> in_ready low during the stall, no beat lost or duplicated, order preserved, held output stable.
REQ-040 Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> out_valid 0 on the next cycle, no stale beat emerges, and a new beat is accepted immediately after release.
